// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Detects load-use hazards, data-memory wait states and taken control
// transfers, and produces PC / IF/ID / ID/EX enables, flushes, bubbles and
// a downstream hold. LOAD_STALL sets how many bubbles a load-use inserts.
module hazard_ctrl #(
    parameter int LOAD_STALL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_hold_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Bubbles still to insert after the first one; LOAD_STALL-1 is at most 3.
    localparam logic [2:0] FIRST_REMAIN = 3'(LOAD_STALL - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  remain;
    logic [2:0]  remain_nxt;
    logic [15:0] stall_cnt;

    logic lu;
    logic mw;
    logic ctrl_xfer;

    // Saturating increment so a long stall run never wraps the counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    // Hazard conditions decoded from the current pipeline register contents.
    always_comb begin
        lu = idex_memread_i && (idex_rt_i != 5'd0) &&
             ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
        mw        = dmem_req_i && !dmem_ack_i;
        ctrl_xfer = branch_taken_i || jump_i;
    end

    // Next-state and control outputs; memory wait beats load-use beats branch.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        state_nxt     = RUN;
        remain_nxt    = remain;

        if (rst_i) begin
            // Hold fetch and inject NOPs everywhere while the core is reset.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            state_nxt     = RUN;
            remain_nxt    = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        pipe_hold_o  = 1'b1;
                        state_nxt    = MEM_WAIT;
                    end else if (lu) begin
                        // A coincident branch/jump is dropped; ID re-presents it.
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_bubble_o = 1'b1;
                        if (LOAD_STALL == 1) begin
                            state_nxt = RUN;
                        end else begin
                            state_nxt  = LU_STALL;
                            remain_nxt = FIRST_REMAIN;
                        end
                    end else if (ctrl_xfer) begin
                        ifid_flush_o = 1'b1;
                        state_nxt    = RUN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                LU_STALL: begin
                    if (mw) begin
                        // Remaining bubbles are dropped; the memory wait covers them.
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        pipe_hold_o  = 1'b1;
                        state_nxt    = MEM_WAIT;
                        remain_nxt   = 3'd0;
                    end else begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_bubble_o = 1'b1;
                        remain_nxt    = remain - 3'd1;
                        state_nxt     = (remain <= 3'd1) ? RUN : LU_STALL;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ack_i) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        pipe_hold_o  = 1'b1;
                        state_nxt    = MEM_WAIT;
                    end else begin
                        // Release cycle: hazards are not evaluated here.
                        state_nxt = RUN;
                    end
                end
                default: begin
                    // Unused encoding: fall back to RUN on the next edge.
                    state_nxt  = RUN;
                    remain_nxt = 3'd0;
                end
            endcase
        end
    end

    // State, bubble countdown and stall statistics register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            remain    <= 3'd0;
            stall_cnt <= 16'd0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            if (!pc_write_o) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    assign state_o     = state;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a LOAD_STALL=1 instance driven from a
// vector table, and a LOAD_STALL=3 instance checked with hand sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        br;
    logic        jmp;
    logic        req;
    logic        ack;

    logic        pcw1, ifw1, fl1, bu1, ho1;
    logic [1:0]  st1;
    logic [15:0] cnt1;
    logic        pcw3, ifw3, fl3, bu3, ho3;
    logic [1:0]  st3;
    logic [15:0] cnt3;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(ex_rt),
        .ifid_rs_i(id_rs), .ifid_rt_i(id_rt), .branch_taken_i(br), .jump_i(jmp),
        .dmem_req_i(req), .dmem_ack_i(ack), .pc_write_o(pcw1), .ifid_write_o(ifw1),
        .ifid_flush_o(fl1), .idex_bubble_o(bu1), .pipe_hold_o(ho1),
        .state_o(st1), .stall_cnt_o(cnt1)
    );

    hazard_ctrl #(.LOAD_STALL(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memread), .idex_rt_i(ex_rt),
        .ifid_rs_i(id_rs), .ifid_rt_i(id_rt), .branch_taken_i(br), .jump_i(jmp),
        .dmem_req_i(req), .dmem_ack_i(ack), .pc_write_o(pcw3), .ifid_write_o(ifw3),
        .ifid_flush_o(fl3), .idex_bubble_o(bu3), .pipe_hold_o(ho3),
        .state_o(st3), .stall_cnt_o(cnt3)
    );

    typedef struct {
        logic        rst, memread;
        logic [4:0]  rt, rs, rtf;
        logic        br, jmp, req, ack;
        logic [4:0]  outs;   // {pc_write, ifid_write, flush, bubble, hold}
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [4:0] DEF = 5'b11000;
    localparam logic [4:0] LUS = 5'b00010;
    localparam logic [4:0] MWH = 5'b00001;
    localparam logic [4:0] RST = 5'b00110;
    localparam logic [4:0] FLS = 5'b11100;

    vec_t tbl[23];

    task automatic drive(input logic r, input logic m, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rtf, input logic b,
                         input logic j, input logic q, input logic a);
        rst = r; memread = m; ex_rt = rt; id_rs = rs; id_rt = rtf;
        br = b; jmp = j; req = q; ack = a;
    endtask

    task automatic chk(input string name, input logic [4:0] ao, input logic [1:0] as,
                       input logic [15:0] ac, input logic [4:0] eo,
                       input logic [1:0] es, input logic [15:0] ec);
        applied++;
        if (ao !== eo || as !== es || ac !== ec) begin
            miscompares++;
            $display("FAIL %s: got outs=%b state=%0d cnt=%0d, want outs=%b state=%0d cnt=%0d",
                     name, ao, as, ac, eo, es, ec);
        end
    endtask

    // Apply inputs after the falling edge, compare 1 time unit later.
    task automatic step3(input string name, input logic r, input logic m,
                         input logic [4:0] rt, input logic [4:0] rs, input logic q,
                         input logic a, input logic [4:0] eo, input logic [1:0] es,
                         input logic [15:0] ec);
        @(negedge clk);
        drive(r, m, rt, rs, 5'd0, 1'b0, 1'b0, q, a);
        #1;
        chk(name, {pcw3, ifw3, fl3, bu3, ho3}, st3, cnt3, eo, es, ec);
    endtask

    initial begin
        //          rst m  rt  rs  rtf br j  req ack  outs st cnt
        tbl[0]  = '{1, 0, 0,  0,  0,  0, 0, 0, 0,  RST, 0, 0};  // held in reset
        tbl[1]  = '{0, 0, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 0};  // idle
        tbl[2]  = '{0, 1, 5,  5,  0,  0, 0, 0, 0,  LUS, 0, 0};  // lu on rs
        tbl[3]  = '{0, 0, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 1};  // single bubble done
        tbl[4]  = '{0, 1, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 1};  // r0 never hazards
        tbl[5]  = '{0, 1, 7,  1,  7,  0, 0, 0, 0,  LUS, 0, 1};  // lu on rt
        tbl[6]  = '{0, 0, 7,  7,  7,  0, 0, 0, 0,  DEF, 0, 2};  // not a load
        tbl[7]  = '{0, 0, 0,  0,  0,  1, 0, 0, 0,  FLS, 0, 2};  // branch flush
        tbl[8]  = '{0, 0, 0,  0,  0,  0, 1, 0, 0,  FLS, 0, 2};  // jump flush
        tbl[9]  = '{0, 1, 3,  3,  0,  1, 0, 0, 0,  LUS, 0, 2};  // lu beats branch
        tbl[10] = '{0, 0, 0,  0,  0,  0, 0, 1, 1,  DEF, 0, 3};  // req+ack same cycle
        tbl[11] = '{0, 0, 0,  0,  0,  0, 0, 1, 0,  MWH, 0, 3};  // mem wait begins
        tbl[12] = '{0, 0, 0,  0,  0,  0, 0, 1, 0,  MWH, 2, 4};
        tbl[13] = '{0, 0, 0,  0,  0,  0, 0, 1, 0,  MWH, 2, 5};
        tbl[14] = '{0, 0, 0,  0,  0,  0, 0, 1, 0,  MWH, 2, 6};
        tbl[15] = '{0, 0, 0,  0,  0,  0, 0, 1, 1,  DEF, 2, 7};  // ack releases
        tbl[16] = '{0, 0, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 7};
        tbl[17] = '{0, 0, 0,  0,  0,  0, 0, 1, 0,  MWH, 0, 7};
        tbl[18] = '{0, 1, 5,  5,  0,  1, 0, 1, 1,  DEF, 2, 8};  // release ignores lu/br
        tbl[19] = '{0, 0, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 8};
        tbl[20] = '{0, 1, 5,  5,  0,  0, 0, 1, 0,  MWH, 0, 8};  // mw beats lu
        tbl[21] = '{1, 0, 0,  0,  0,  0, 0, 1, 0,  RST, 2, 9};  // reset mid-wait
        tbl[22] = '{0, 0, 0,  0,  0,  0, 0, 0, 0,  DEF, 0, 0};  // cleared

        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].memread, tbl[i].rt, tbl[i].rs, tbl[i].rtf,
                  tbl[i].br, tbl[i].jmp, tbl[i].req, tbl[i].ack);
            #1;
            chk($sformatf("vec%0d", i), {pcw1, ifw1, fl1, bu1, ho1}, st1, cnt1,
                tbl[i].outs, tbl[i].st, tbl[i].cnt);
        end

        // LOAD_STALL=3: one-cycle hazard yields three bubbles, states 0,1,1,0.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step3("ls3_lu",    1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, LUS, 2'd0, 16'd0);
        step3("ls3_b2",    1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, LUS, 2'd1, 16'd1);
        step3("ls3_b3",    1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, LUS, 2'd1, 16'd2);
        step3("ls3_done",  1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 2'd0, 16'd3);
        step3("ls3_idle",  1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 2'd0, 16'd3);

        // LOAD_STALL=3: memory wait inside the stall drops remaining bubbles.
        step3("ls3_rst",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, RST, 2'd0, 16'd3);
        step3("ls3_lu2",   1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 1'b0, LUS, 2'd0, 16'd0);
        step3("ls3_mw",    1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, MWH, 2'd1, 16'd1);
        step3("ls3_rel",   1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, DEF, 2'd2, 16'd2);
        step3("ls3_run",   1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 2'd0, 16'd2);

        // LOAD_STALL=3: reset in the middle of the bubble run.
        step3("ls3_lu3",   1'b0, 1'b1, 5'd4, 5'd4, 1'b0, 1'b0, LUS, 2'd0, 16'd2);
        step3("ls3_rstmid",1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, RST, 2'd1, 16'd3);
        step3("ls3_clr",   1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 2'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: LOAD_STALL, default 1, range 1..4, the number of bubble cycles inserted per load-use hazard.
REQ-002 The block SHALL have these ports, in this order:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- idex_memread_i  in  1  the instruction in ID/EX is a load.
- idex_rt_i  in  5  destination register of the instruction in ID/EX.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- branch_taken_i  in  1  branch resolved taken in ID.
- jump_i  in  1  jump decoded in ID.
- dmem_req_i  in  1  data memory access presented this cycle.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC register load enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_bubble_o  out  1  ID/EX loads zero WB/M/EX control fields.
- pipe_hold_o  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- state_o  out  2  current state: RUN=0, LU_STALL=1, MEM_WAIT=2.
- stall_cnt_o  out  16  saturating count of cycles with pc_write_o=0.

Function
REQ-003 Load-use hazard (lu) SHALL be defined as: idex_memread_i=1 and idex_rt_i!=0 and (idex_rt_i==ifid_rs_i or idex_rt_i==ifid_rt_i).
REQ-004 Memory wait (mw) SHALL be defined as: dmem_req_i=1 and dmem_ack_i=0.
REQ-005 All outputs except state_o and stall_cnt_o SHALL be combinational functions of the current state and the current inputs.
REQ-006 Default outputs SHALL be: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=0.
REQ-007 Priority in every state SHALL be: mw, then lu/LU_STALL, then branch/jump.
REQ-008 RUN with mw: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, idex_bubble_o=0; next state MEM_WAIT.
REQ-009 RUN with lu and no mw: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
- If LOAD_STALL=1, next state RUN.
- Otherwise, next state LU_STALL with remaining counter = LOAD_STALL-1.
REQ-010 RUN with (branch_taken_i or jump_i), no lu and no mw: ifid_flush_o=1, pc_write_o=1; next state RUN.
REQ-011 When branch/jump coincides with lu, the branch/jump SHALL be ignored that cycle; ID re-presents it after the stall.
REQ-012 LU_STALL with no mw: outputs as in REQ-009, and the remaining counter decrements.
- Remaining counter = 1 in that cycle: next state RUN.
- Otherwise: stay in LU_STALL.
- This gives exactly LOAD_STALL consecutive bubble cycles per hazard.
REQ-013 LU_STALL with mw: outputs as in REQ-008; next state MEM_WAIT; the remaining stall cycles are discarded.
REQ-014 MEM_WAIT with dmem_ack_i=0: outputs as in REQ-008; stay in MEM_WAIT.
REQ-015 MEM_WAIT with dmem_ack_i=1: default outputs (lu and branch/jump are not evaluated); next state RUN.
REQ-016 RUN with dmem_req_i=1 and dmem_ack_i=1 in the same cycle SHALL NOT enter MEM_WAIT.
REQ-017 stall_cnt_o SHALL increment by 1 on each clock edge where pc_write_o=0, and saturate at 16'hFFFF.
REQ-018 state_o SHALL reflect the registered state; encoding 3 is unreachable and SHALL recover to RUN on the next edge.

Reset
REQ-019 When rst_i=1 at a clock edge, the following SHALL take effect on that edge regardless of the current state, including mid-MEM_WAIT or mid-LU_STALL:
- state = RUN.
- remaining counter = 0.
- stall_cnt_o = 0.
REQ-020 While rst_i=1, outputs SHALL be: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pipe_hold_o=0.
REQ-021 In the first cycle after rst_i deasserts, the block SHALL be in RUN and behave per REQ-008 to REQ-010.

Verification
REQ-022 Load-use, LOAD_STALL=1: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle -> one cycle of pc_write_o=0 and idex_bubble_o=1, state_o stays 0, stall_cnt_o=1.
REQ-023 Load-use, LOAD_STALL=3: same stimulus -> exactly 3 bubble cycles, state_o sequence 0,1,1,0, stall_cnt_o=3.
REQ-024 No hazard on r0: idex_rt_i=0, ifid_rs_i=0, idex_memread_i=1 -> no stall, stall_cnt_o=0.
REQ-025 Memory wait: dmem_req_i=1 with ack held low 4 cycles, then ack=1 -> pipe_hold_o=1 for 4 cycles, state_o=2, release on the ack cycle, stall_cnt_o=4; also check simultaneous req+ack -> no hold.
REQ-026 Priority: branch_taken_i=1 with lu -> stall wins, ifid_flush_o=0; then lu with mw -> MEM_WAIT; then rst_i=1 mid-MEM_WAIT -> state_o=0 and stall_cnt_o=0 next cycle.
